// File: rtl/mem_req_pkg.sv
// Shared types for the memory requester and the datapath's MAR/MDR control:
// FSM state encoding plus the request and response bundles.
package mem_req_pkg;

  localparam int PKG_WIDTH  = 32;
  localparam int PKG_DEPTH  = 256;
  localparam int PKG_ABITS  = $clog2(PKG_DEPTH);
  localparam int PKG_MAXLEN = 16;
  localparam int PKG_LBITS  = (PKG_MAXLEN > 1) ? $clog2(PKG_MAXLEN) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [PKG_ABITS-1:0] address;
    logic [PKG_WIDTH-1:0] wdata;
    logic [PKG_LBITS-1:0] len;
  } req_t;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] data;
    logic                 write;
    logic                 error;
    logic                 last;
  } rsp_t;

endpackage

// File: rtl/mem_requester_if.sv
// Request, response and memory-pin bundle of the memory requester.
// The master side is the requester itself; the slave side is its environment.
interface mem_requester_if #(
  parameter int WIDTH = 32,
  parameter int ABITS = 8,
  parameter int LBITS = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ABITS-1:0] req_address;
  logic [WIDTH-1:0] req_wdata;
  logic [LBITS-1:0] req_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_write;
  logic             rsp_error;
  logic             rsp_last;
  logic             mem_write;
  logic             mem_read;
  logic [ABITS-1:0] mem_address;
  logic [WIDTH-1:0] mem_write_data;
  logic [WIDTH-1:0] mem_read_data;
  logic             busy;

  modport master (
    input  req_valid, req_write, req_address, req_wdata, req_len, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_write, rsp_error, rsp_last,
           mem_write, mem_read, mem_address, mem_write_data, busy
  );

  modport slave (
    output req_valid, req_write, req_address, req_wdata, req_len, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_write, rsp_error, rsp_last,
           mem_write, mem_read, mem_address, mem_write_data, busy
  );
endinterface

// File: rtl/mem_addr_counter.sv
// Burst address and remaining-beat tracker: loaded when a request is accepted,
// stepped once per continued read beat, address wrapping at DEPTH.
module mem_addr_counter #(
  parameter int DEPTH = 256,
  parameter int ABITS = $clog2(DEPTH),
  parameter int LBITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [ABITS-1:0] load_address,
  input  logic [LBITS-1:0] load_len,
  output logic [ABITS-1:0] address,
  output logic             zero
);
  localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(DEPTH - 1);

  logic [ABITS-1:0] address_r;
  logic [LBITS-1:0] remaining_r;
  logic [ABITS-1:0] next_address_s;

  // Next word address; folds to 0 after the last word even when DEPTH is not a power of 2.
  always_comb begin
    next_address_s = '0;
    if (address_r == LAST_ADDR) begin
      next_address_s = '0;
    end else begin
      next_address_s = address_r + ABITS'(1);
    end
  end

  // Load takes priority; a step advances the address and consumes one beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      address_r   <= '0;
      remaining_r <= '0;
    end else if (load) begin
      address_r   <= load_address;
      remaining_r <= load_len;
    end else if (step) begin
      address_r   <= next_address_s;
      remaining_r <= remaining_r - LBITS'(1);
    end else begin
      address_r   <= address_r;
      remaining_r <= remaining_r;
    end
  end

  assign address = address_r;
  assign zero    = (remaining_r == '0);
endmodule

// File: rtl/mem_requester.sv
// Memory requester: accepts single-word writes and read bursts on a valid/ready port and
// sequences them onto the single-port synchronous memory, one beat in flight at a time.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int WIDTH  = PKG_WIDTH,
  parameter int DEPTH  = PKG_DEPTH,
  parameter int ABITS  = $clog2(DEPTH),
  parameter int MAXLEN = PKG_MAXLEN,
  parameter int LBITS  = (MAXLEN > 1) ? $clog2(MAXLEN) : 1
) (
  input logic             clock,
  input logic             reset,
  mem_requester_if.master bus
);
  localparam logic [ABITS:0] DEPTH_W = (ABITS+1)'(DEPTH);

  state_t           state_r;
  rsp_t             rsp_r;
  logic             write_r;
  logic [WIDTH-1:0] wdata_r;
  logic             rsp_valid_r;
  logic             req_ready_r;
  logic             mem_write_r;
  logic             mem_read_r;
  logic             busy_r;

  req_t             req_s;
  logic             addr_err_s;
  logic             accept_s;
  logic             rsp_done_s;
  logic             more_s;
  logic             cnt_step_s;
  logic             cnt_zero_s;
  logic [ABITS-1:0] cnt_address_s;

  // Bundle the request port, classify it and decode the handshakes.
  always_comb begin
    req_s.write   = bus.req_write;
    req_s.address = bus.req_address;
    req_s.wdata   = bus.req_wdata;
    req_s.len     = bus.req_len;
    addr_err_s    = ({1'b0, bus.req_address} >= DEPTH_W);
    accept_s      = (state_r == IDLE) && bus.req_valid;
    rsp_done_s    = (state_r == RESP) && bus.rsp_ready;
    more_s        = !write_r && !rsp_r.error && !cnt_zero_s;
    cnt_step_s    = rsp_done_s && more_s;
  end

  mem_addr_counter #(
    .DEPTH (DEPTH),
    .ABITS (ABITS),
    .LBITS (LBITS)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .load         (accept_s),
    .step         (cnt_step_s),
    .load_address (req_s.address),
    .load_len     (req_s.len),
    .address      (cnt_address_s),
    .zero         (cnt_zero_s)
  );

  // Request sequencing; every strobe and flag leaving the block is a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      wdata_r     <= '0;
      rsp_r       <= '0;
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            write_r     <= req_s.write;
            wdata_r     <= req_s.wdata;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            // Out-of-range start: answer immediately without touching the memory.
            if (addr_err_s) begin
              rsp_r       <= '{data: '0, write: req_s.write, error: 1'b1, last: 1'b1};
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end else if (req_s.write) begin
              mem_write_r <= 1'b1;
              state_r     <= WRITE;
            end else begin
              mem_read_r <= 1'b1;
              state_r    <= READ;
            end
          end
        end
        WRITE: begin
          mem_write_r <= 1'b0;
          rsp_r       <= '{data: '0, write: 1'b1, error: 1'b0, last: 1'b1};
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        READ: begin
          mem_read_r <= 1'b0;
          state_r    <= CAPTURE;
        end
        CAPTURE: begin
          rsp_r       <= '{data: bus.mem_read_data, write: 1'b0, error: 1'b0, last: cnt_zero_s};
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
            if (more_s) begin
              mem_read_r <= 1'b1;
              state_r    <= READ;
            end else begin
              req_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end
          end
        end
        default: begin
          mem_write_r <= 1'b0;
          mem_read_r  <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_r;
  assign bus.rsp_valid      = rsp_valid_r;
  assign bus.rsp_data       = rsp_r.data;
  assign bus.rsp_write      = rsp_r.write;
  assign bus.rsp_error      = rsp_r.error;
  assign bus.rsp_last       = rsp_r.last;
  assign bus.mem_write      = mem_write_r;
  assign bus.mem_read       = mem_read_r;
  assign bus.mem_address    = cnt_address_s;
  assign bus.mem_write_data = wdata_r;
  assign bus.busy           = busy_r;
endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: directed cases plus a random phase, checked by a scoreboard
// fed from a plain array model of memory contents.
module tb_mem_requester;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 256;
  localparam int ABITS   = 8;
  localparam int MAXLEN  = 16;
  localparam int LBITS   = 4;
  localparam int DEPTH_E = 200;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             wr;
    logic             err;
    logic             last;
    int               lat;
  } exp_rsp_t;

  typedef struct {
    logic             wr;
    logic [ABITS-1:0] addr;
    logic [WIDTH-1:0] data;
  } exp_mem_t;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic mem_clr = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   beats_done = 0;
  int   hold_cnt   = 0;
  bit   bp_mode    = 1'b0;

  exp_rsp_t rsp_q[$];
  exp_mem_t mem_q[$];
  exp_rsp_t rsp_e_q[$];
  exp_mem_t mem_e_q[$];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_r;

  always #5 clock = ~clock;

  mem_requester_if #(.WIDTH(WIDTH), .ABITS(ABITS), .LBITS(LBITS)) b ();
  mem_requester_if #(.WIDTH(WIDTH), .ABITS(ABITS), .LBITS(LBITS)) e ();

  mem_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
    .clock (clock), .reset (reset), .bus (b.master));
  mem_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH_E), .MAXLEN(MAXLEN)) dut_e (
    .clock (clock), .reset (reset), .bus (e.master));

  // Single-port synchronous memory: read data valid the cycle after mem_read.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_r <= '0;
    end else begin
      if (b.mem_write) mem[b.mem_address] <= b.mem_write_data;
      if (b.mem_read) rd_r <= mem[b.mem_address];
    end
  end
  assign b.mem_read_data = rd_r;
  assign e.mem_read_data = '0;
  assign e.rsp_ready     = 1'b1;

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no/extra event expected a matching one", nm);
  endfunction

  task automatic check_reset_vals(input string nm);
    chk(nm, {b.req_ready, b.rsp_valid, b.rsp_write, b.rsp_error, b.rsp_last, b.mem_write,
             b.mem_read, b.busy, b.rsp_data, b.mem_address, b.mem_write_data},
        {1'b1, 7'd0, 32'd0, 8'd0, 32'd0});
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin : rsp_ready_driver
    forever begin
      @(posedge clock);
      #2;
      if (hold_cnt > 0) begin
        b.rsp_ready = 1'b0;
        hold_cnt    = hold_cnt - 1;
      end else begin
        b.rsp_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Issue one request; expected responses and memory operations are queued up front.
  task automatic issue(input bit on_e, input bit wr, input int addr, input logic [WIDTH-1:0] wd,
                       input int len);
    int n = 0;
    int dep;
    int a;
    exp_rsp_t r;
    exp_mem_t m;
    dep = on_e ? DEPTH_E : DEPTH;
    @(posedge clock);
    #2;
    while (!(on_e ? e.req_ready : b.req_ready) && n < 400) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (!(on_e ? e.req_ready : b.req_ready)) begin
      fail("req_ready_wait");
      return;
    end
    if (addr >= dep) begin
      r.data = '0; r.wr = wr; r.err = 1'b1; r.last = 1'b1; r.lat = -1;
      if (on_e) rsp_e_q.push_back(r); else rsp_q.push_back(r);
    end else if (wr) begin
      ref_mem[addr] = wd;
      r.data = '0; r.wr = 1'b1; r.err = 1'b0; r.last = 1'b1; r.lat = 1;
      m.wr = 1'b1; m.addr = ABITS'(addr); m.data = wd;
      rsp_q.push_back(r);
      mem_q.push_back(m);
    end else begin
      for (int i = 0; i <= len; i++) begin
        a = (addr + i) % dep;
        r.data = on_e ? '0 : ref_mem[a]; r.wr = 1'b0; r.err = 1'b0;
        r.last = (i == len); r.lat = 2;
        m.wr = 1'b0; m.addr = ABITS'(a); m.data = '0;
        if (on_e) begin
          rsp_e_q.push_back(r);
          mem_e_q.push_back(m);
        end else begin
          rsp_q.push_back(r);
          mem_q.push_back(m);
        end
      end
    end
    if (on_e) begin
      e.req_write = wr; e.req_address = ABITS'(addr); e.req_wdata = wd;
      e.req_len = LBITS'(len); e.req_valid = 1'b1;
    end else begin
      b.req_write = wr; b.req_address = ABITS'(addr); b.req_wdata = wd;
      b.req_len = LBITS'(len); b.req_valid = 1'b1;
    end
    @(posedge clock);
    #2;
    b.req_valid = 1'b0;
    e.req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int tgt);
    int n = 0;
    while (beats_done < tgt && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (beats_done < tgt) fail("beat_wait");
  endtask

  initial begin : mon_main
    exp_rsp_t    cur;
    exp_mem_t    m;
    int          base;
    bit          seen;
    logic [34:0] held;
    base = 0;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("strobe_excl", b.mem_read & b.mem_write, 1'b0);
        if (b.mem_read || b.mem_write) begin
          if (mem_q.size() == 0) begin
            fail("mem_unexpected");
          end else begin
            m = mem_q.pop_front();
            chk("mem_write", b.mem_write, m.wr);
            chk("mem_address", b.mem_address, m.addr);
            if (m.wr) chk("mem_write_data", b.mem_write_data, m.data);
          end
        end
        if (b.req_valid && b.req_ready) begin
          base = cyc + 1;
          seen = 1'b0;
        end
        if (b.rsp_valid) begin
          chk("rsp_busy_strobes", {b.busy, b.mem_read, b.mem_write}, 3'b100);
          if (!seen) begin
            seen = 1'b1;
            held = {b.rsp_data, b.rsp_write, b.rsp_error, b.rsp_last};
            if (rsp_q.size() == 0) begin
              fail("rsp_unexpected");
            end else begin
              cur = rsp_q.pop_front();
              chk("rsp_data", b.rsp_data, cur.data);
              chk("rsp_write", b.rsp_write, cur.wr);
              chk("rsp_error", b.rsp_error, cur.err);
              chk("rsp_last", b.rsp_last, cur.last);
              if (cur.lat >= 0) chk("rsp_latency", 96'(cyc - base), 96'(cur.lat));
            end
          end else begin
            chk("rsp_stable", {b.rsp_data, b.rsp_write, b.rsp_error, b.rsp_last}, held);
          end
          if (b.rsp_ready) begin
            base = cyc + 1;
            seen = 1'b0;
            beats_done++;
          end
        end
      end
    end
  end

  initial begin : mon_e
    exp_rsp_t cur;
    exp_mem_t m;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (e.mem_read || e.mem_write) begin
          if (mem_e_q.size() == 0) begin
            fail("e_mem_unexpected");
          end else begin
            m = mem_e_q.pop_front();
            chk("e_mem_write", e.mem_write, m.wr);
            chk("e_mem_address", e.mem_address, m.addr);
          end
        end
        if (e.rsp_valid) begin
          if (rsp_e_q.size() == 0) begin
            fail("e_rsp_unexpected");
          end else begin
            cur = rsp_e_q.pop_front();
            chk("e_rsp", {e.rsp_data, e.rsp_write, e.rsp_error, e.rsp_last},
                {cur.data, cur.wr, cur.err, cur.last});
          end
        end
      end
    end
  end

  initial begin : main
    int n;
    int base_beats;
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_address = '0; b.req_wdata = '0;
    b.req_len = '0; b.rsp_ready = 1'b1;
    e.req_valid = 1'b0; e.req_write = 1'b0; e.req_address = '0; e.req_wdata = '0;
    e.req_len = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clock);
    #2;
    reset   = 1'b0;
    mem_clr = 1'b0;
    @(negedge clock);
    check_reset_vals("reset_state");

    issue(1'b0, 1'b1, 'h10, 32'hDEADBEEF, 0);
    issue(1'b0, 1'b0, 'h10, 32'h0, 0);
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 'h20 + i, WIDTH'(i * 3), 0);

    // Burst with the consumer stalling for five cycles after the second beat.
    issue(1'b0, 1'b0, 'h20, 32'h0, 3);
    base_beats = beats_done;
    wait_beats(base_beats + 2);
    hold_cnt = 5;

    issue(1'b0, 1'b0, DEPTH - 2, 32'h0, 3);

    // Reset while the second beat of a long burst is being fetched.
    issue(1'b0, 1'b0, 'h40, 32'h0, 7);
    base_beats = beats_done;
    wait_beats(base_beats + 1);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    rsp_q.delete();
    mem_q.delete();
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("reset_mid_burst");
    issue(1'b0, 1'b0, 'h10, 32'h0, 0);

    issue(1'b1, 1'b0, DEPTH_E, 32'h0, 5);
    issue(1'b1, 1'b0, DEPTH_E - 1, 32'h0, 1);

    bp_mode = 1'b1;
    repeat (40) begin
      issue(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), $urandom,
            int'($urandom_range(0, MAXLEN - 1)));
    end

    n = 0;
    while ((b.busy || e.busy || rsp_q.size() != 0 || rsp_e_q.size() != 0) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("rsp_q_drained", 96'(rsp_q.size() + rsp_e_q.size()), 96'(0));
    chk("mem_q_drained", 96'(mem_q.size() + mem_e_q.size()), 96'(0));
    chk("idle_at_end", {b.busy, b.req_ready, e.busy, e.req_ready}, 4'b0101);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
